// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icodes, register indices, data width and register-file FSM states
package y86_pkg;
    localparam int WIDTH = 64;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] RSP      = 4'd4;
    typedef enum logic {INIT, RUN} rf_state_t;
endpackage

// File: rtl/reg_array.sv
// reg_array: NREGS x WIDTH register storage, two write ports (M wins on a shared index), two async reads
module reg_array
    import y86_pkg::*;
#(
    parameter int WIDTH = y86_pkg::WIDTH,
    parameter int NREGS = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we_e,
    input  logic [3:0]       dst_e,
    input  logic [WIDTH-1:0] wr_e,
    input  logic             we_m,
    input  logic [3:0]       dst_m,
    input  logic [WIDTH-1:0] wr_m,
    input  logic [3:0]       idx_a,
    input  logic [3:0]       idx_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b
);
    logic [WIDTH-1:0] mem [NREGS];

    // M write is issued after E so a shared destination keeps the M data; indices past NREGS are dropped
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            for (int k = 0; k < NREGS; k++) mem[k] <= '0;
        end else begin
            if (we_e && 32'(dst_e) < NREGS) mem[dst_e] <= wr_e;
            if (we_m && 32'(dst_m) < NREGS) mem[dst_m] <= wr_m;
        end

    // unbacked indices such as RNONE read as zero
    always_comb begin
        rd_a = (32'(idx_a) < NREGS) ? mem[idx_a] : '0;
        rd_b = (32'(idx_b) < NREGS) ? mem[idx_b] : '0;
    end
endmodule

// File: rtl/decode_reg_read.sv
// decode_reg_read: Y86-64 SEQ decode source select, post-reset scrub FSM and register read; RF_BYPASS_EN adds write-through forwarding
module decode_reg_read
    import y86_pkg::*;
#(
    parameter int WIDTH   = y86_pkg::WIDTH,
    parameter int NREGS   = 15,
    parameter int RSP_IDX = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       in_code,
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    input  logic             w_en,
    input  logic [3:0]       w_dst_e,
    input  logic [WIDTH-1:0] w_val_e,
    input  logic [3:0]       w_dst_m,
    input  logic [WIDTH-1:0] w_val_m,
    output logic [3:0]       src_a,
    output logic [3:0]       src_b,
    output logic [WIDTH-1:0] val_a,
    output logic [WIDTH-1:0] val_b,
    output logic             rf_busy
);
    rf_state_t        state;
    logic [3:0]       cnt;
    logic             run;
    logic             we_e;
    logic             we_m;
    logic [3:0]       dst_e;
    logic [WIDTH-1:0] wr_e;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // scrub sweep: one register per cycle, then hand the write ports to writeBack
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state   <= INIT;
            cnt     <= '0;
            rf_busy <= 1'b1;
        end else if (state == INIT) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(NREGS - 1)) begin
                state   <= RUN;
                rf_busy <= 1'b0;
            end
        end

    assign run  = state == RUN;
    assign we_e = run ? w_en : 1'b1;
    assign dst_e = run ? w_dst_e : cnt;
    assign wr_e = run ? w_val_e : '0;
    assign we_m = run && w_en;

    // operand sources follow the Y86-64 decode table; unknown icodes select nothing
    always_comb begin
        src_a = (in_code inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? ra :
                (in_code inside {I_RET, I_POPQ}) ? 4'(RSP_IDX) : RNONE;
        src_b = (in_code inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? rb :
                (in_code inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? 4'(RSP_IDX) : RNONE;
    end

    reg_array #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regs (
        .clock   (clock),
        .reset_n (reset_n),
        .we_e    (we_e),
        .dst_e   (dst_e),
        .wr_e    (wr_e),
        .we_m    (we_m),
        .dst_m   (w_dst_m),
        .wr_m    (w_val_m),
        .idx_a   (src_a),
        .idx_b   (src_b),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

`ifdef RF_BYPASS_EN
    // forward this cycle's write data to a matching reader, M before E like the array itself
    always_comb begin
        val_a = (we_m && src_a != RNONE && w_dst_m == src_a) ? w_val_m :
                (we_m && src_a != RNONE && w_dst_e == src_a) ? w_val_e : rd_a;
        val_b = (we_m && src_b != RNONE && w_dst_m == src_b) ? w_val_m :
                (we_m && src_b != RNONE && w_dst_e == src_b) ? w_val_e : rd_b;
    end
`else
    assign val_a = rd_a;
    assign val_b = rd_b;
`endif
endmodule

// File: tb/tb_decode_reg_read.sv
// tb_decode_reg_read: directed and random checks of decode_reg_read against a register-file model
module tb_decode_reg_read;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  in_code, ra, rb, w_dst_e, w_dst_m;
    logic        w_en;
    logic [63:0] w_val_e, w_val_m;
    logic [3:0]  src_a, src_b;
    logic [63:0] val_a, val_b;
    logic        rf_busy;

    int passed = 0;
    int total = 0;
    logic [63:0] regs [16];
    bit          running = 0;

    always #5 clock = ~clock;

    decode_reg_read dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in_code (in_code),
        .ra      (ra),
        .rb      (rb),
        .w_en    (w_en),
        .w_dst_e (w_dst_e),
        .w_val_e (w_val_e),
        .w_dst_m (w_dst_m),
        .w_val_m (w_val_m),
        .src_a   (src_a),
        .src_b   (src_b),
        .val_a   (val_a),
        .val_b   (val_b),
        .rf_busy (rf_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] exp_src_a(input logic [3:0] ic, input logic [3:0] a);
        case (ic)
            4'h2, 4'h4, 4'h6, 4'hA: return a;
            4'h9, 4'hB:             return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] exp_src_b(input logic [3:0] ic, input logic [3:0] b);
        case (ic)
            4'h4, 4'h5, 4'h6:       return b;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'd4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [3:0] idx);
        if (idx == 4'hF) return 64'd0;
`ifdef RF_BYPASS_EN
        if (running && w_en && w_dst_m == idx) return w_val_m;
        if (running && w_en && w_dst_e == idx) return w_val_e;
`endif
        return regs[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) regs[i] = 64'd0;
    endtask

    task automatic step(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic en, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        logic [3:0] sa, sb;
        in_code = ic; ra = a; rb = b;
        w_en = en; w_dst_e = de; w_val_e = ve; w_dst_m = dm; w_val_m = vm;
        @(negedge clock);
        sa = exp_src_a(ic, a);
        sb = exp_src_b(ic, b);
        check("src_a", 64'(src_a), 64'(sa));
        check("src_b", 64'(src_b), 64'(sb));
        check("val_a", val_a, model_read(sa));
        check("val_b", val_b, model_read(sb));
        @(posedge clock);
        if (running && en) begin
            if (de != 4'hF) regs[de] = ve;
            if (dm != 4'hF) regs[dm] = vm;
        end
        #1;
    endtask

    initial begin
        int cyc;
        clear_model();
        reset_n = 1'b0;
        in_code = 4'h6; ra = 4'd0; rb = 4'd1;
        w_en = 1'b0; w_dst_e = 4'hF; w_dst_m = 4'hF; w_val_e = '0; w_val_m = '0;
        @(negedge clock);
        check("reset_busy", 64'(rf_busy), 64'd1);
        check("reset_val_a", val_a, 64'd0);
        check("reset_val_b", val_b, 64'd0);
        reset_n = 1'b1;
        cyc = 0;
        while (rf_busy && cyc < 40) begin
            if (cyc == 2) begin
                w_en = 1'b1; w_dst_e = 4'd2; w_val_e = 64'd99;
            end
            if (cyc == 3) begin
                w_en = 1'b0; w_dst_e = 4'hF; w_val_e = '0;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        check("init_cycles", 64'(cyc), 64'd15);
        check("busy_low", 64'(rf_busy), 64'd0);
        running = 1;

        for (int i = 0; i < 16; i++) step(4'h6, 4'(i), 4'(i), 1'b0, 4'hF, 0, 4'hF, 0);
        step(4'h6, 4'd2, 4'hF, 1'b0, 4'hF, 0, 4'hF, 0);
        check("init_write_ignored", regs[2], 64'd0);

        step(4'h0, 4'd0, 4'd0, 1'b1, 4'd1, 64'd21, 4'hF, 0);
        step(4'h2, 4'd1, 4'd0, 1'b0, 4'hF, 0, 4'hF, 0);
        step(4'h0, 4'd0, 4'd0, 1'b1, 4'd4, 64'd77, 4'd4, 64'd58);
        step(4'hB, 4'd0, 4'd0, 1'b0, 4'hF, 0, 4'hF, 0);
        step(4'h0, 4'd0, 4'd0, 1'b1, 4'd3, 64'd256, 4'd5, 64'd10);
        step(4'h6, 4'd3, 4'd5, 1'b0, 4'hF, 0, 4'hF, 0);

        in_code = 4'h6; ra = 4'd1; rb = 4'hF;
        w_en = 1'b1; w_dst_e = 4'd1; w_val_e = 64'd7; w_dst_m = 4'hF; w_val_m = '0;
        @(negedge clock);
`ifdef RF_BYPASS_EN
        check("bypass_same_cycle", val_a, 64'd7);
`else
        check("no_bypass_old", val_a, 64'd21);
`endif
        @(posedge clock);
        regs[1] = 64'd7;
        #1;
        w_en = 1'b0;
        @(negedge clock);
        check("after_edge", val_a, 64'd7);

        for (int n = 0; n < 300; n++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 4'($urandom_range(0, 15)), {$urandom, $urandom});

        step(4'h0, 4'd0, 4'd0, 1'b1, 4'd6, 64'hABCD, 4'd7, 64'h1234);
        in_code = 4'h6; ra = 4'd6; rb = 4'd7;
        w_en = 1'b1; w_dst_e = 4'd6; w_val_e = 64'h5555; w_dst_m = 4'd7; w_val_m = 64'h6666;
        @(negedge clock);
        reset_n = 1'b0;
        clear_model();
        #1;
        check("midreset_busy", 64'(rf_busy), 64'd1);
        check("midreset_val_a", val_a, 64'd0);
        check("midreset_val_b", val_b, 64'd0);
        @(posedge clock);
        #1;
        check("held_reset_val_a", val_a, 64'd0);
        check("held_reset_val_b", val_b, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_reg_read.md
Name: decode_reg_read

Overview:
- Y86-64 SEQ decode stage: owns the 15-entry architectural register file and produces val_a and val_b for execute.
- Read side of the register file. The writeBack stage computes destinations and drives this block's two write ports.
- Source selection from icode/ra/rb follows the Y86-64 ISA.
- Storage is sequential. Reads are combinational.

Parameters:
- WIDTH, 64, data word width.
- NREGS, 15, architectural registers %rax..%r14; index 4'hF = RNONE.
- RSP_IDX, 4, stack pointer index.

Ports:
- clock  in  1  system clock, rising edge active.
- reset_n  in  1  asynchronous active-low reset.
- in_code  in  4  icode of the current instruction.
- ra  in  4  rA field.
- rb  in  4  rB field.
- w_en  in  1  write-port enable; qualifies both write ports for this cycle.
- w_dst_e  in  4  E-port destination index from writeBack (4'hF = none).
- w_val_e  in  WIDTH  E-port data.
- w_dst_m  in  4  M-port destination index from writeBack (4'hF = none).
- w_val_m  in  WIDTH  M-port data.
- src_a  out  4  selected A source index.
- src_b  out  4  selected B source index.
- val_a  out  WIDTH  register value for src_a; 0 when src_a = RNONE.
- val_b  out  WIDTH  register value for src_b; 0 when src_b = RNONE.
- rf_busy  out  1  high during the post-reset init sweep; decode must stall while high.

Behaviour:
- Reset (asynchronous, active-low):
  - all 15 registers clear to 0 immediately;
  - rf_busy asserts;
  - FSM enters INIT.
- FSM states: INIT, RUN.
  - INIT: a 4-bit sweep counter runs 0..14, one cycle per index, and rewrites each register to 0 (scrub).
  - Write ports are ignored in INIT.
  - At count 14 the FSM moves to RUN and rf_busy deasserts on the following edge.
  - INIT therefore lasts exactly 15 cycles after reset_n rises.
- src_a selection:
  - rA for icode 2, 4, 6, A;
  - RSP_IDX for 9, B;
  - else RNONE.
- src_b selection:
  - rB for icode 4, 5, 6;
  - RSP_IDX for 8, 9, A, B;
  - else RNONE.
- Reads are combinational from the array, with no latency. The value written on a clock edge is visible after that edge.
- Writes happen on the rising edge, in RUN, when w_en = 1. A port with destination 4'hF writes nothing.
- Simultaneous writes:
  - w_dst_e == w_dst_m (both ≠ F): M-port data wins (popq %rsp semantics);
  - distinct destinations: both written in the same edge.
- Index 4'hF is never stored. Reads of index F return 0.
- Reset asserted mid-write: reset dominates and the array clears regardless of write inputs.
- Unknown icodes (C..F) read as RNONE on both ports.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - same-cycle write-through forwarding;
  - if w_en, RUN state, and w_dst_m/w_dst_e matches src_a or src_b, val_a/val_b return the incoming write data;
  - M priority over E applies to forwarding as well.
- Undefined: val_a/val_b return only the array contents, so new data appears after the edge.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT=0 .. I_POPQ=B);
  - RNONE=4'hF and RSP=4'd4;
  - WIDTH;
  - the FSM state encoding.
- Sub-module reg_array: 15xWIDTH storage with two write ports, M-priority, two async read ports, and reset clear.
- decode_reg_read holds the source selection, the FSM, and the bypass logic.

Test Plan:
- Reset release -> rf_busy high for exactly 15 cycles, then low; val_a = val_b = 0 for every index.
- RUN: write w_dst_e=1, w_val_e=21, w_en=1; then icode=2, ra=1 -> src_a=1, val_a=21; src_b=F, val_b=0.
- Conflict: w_dst_e=4, w_val_e=77, w_dst_m=4, w_val_m=58 in one cycle; then icode=B -> src_a=4, val_a=58, src_b=4, val_b=58.
- Dual write: dst_e=3/256, dst_m=5/10 in the same edge; icode=6, ra=3, rb=5 -> val_a=256, val_b=10.
- Write during INIT (cycle 3 after reset): dst_e=2, val 99 -> register 2 still reads 0 after rf_busy falls.
- With RF_BYPASS_EN: dst_e=1, val 7 presented while icode=6, ra=1 -> val_a=7 in the same cycle. Without the macro -> old value until after the edge.
